rotary_accum: RTL and testbench

ROTARY_ACCUM -- requirements
Module: rotary_accum

---
 rtl/rotary_accum.sv | 157 +++++++++++++++
 tb/tb_rotary_accum.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_accum.sv
// Dual rotary-encoder position accumulator with an Avalon-MM register interface.
// Each channel counts cw/ccw pulses within 0..LIMIT, wrapping or saturating under CTRL.WRAP.
module rotary_accum #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LIMIT_RESET = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rotary_left_cw,
    input  logic        rotary_left_ccw,
    input  logic        rotary_right_cw,
    input  logic        rotary_right_ccw,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam logic [2:0] AddrLeft   = 3'd0;
    localparam logic [2:0] AddrRight  = 3'd1;
    localparam logic [2:0] AddrLimit  = 3'd2;
    localparam logic [2:0] AddrCtrl   = 3'd3;
    localparam logic [2:0] AddrStatus = 3'd4;

    logic [WIDTH-1:0] r_left_pos;
    logic [WIDTH-1:0] r_right_pos;
    logic [WIDTH-1:0] r_limit;
    logic             r_wrap;
    logic             r_irq_en;
    logic             r_left_chg;
    logic             r_right_chg;
    logic             r_irq;
    logic [31:0]      r_readdata;

    logic             w_wr_left;
    logic             w_wr_right;
    logic             w_wr_limit;
    logic             w_wr_ctrl;
    logic             w_wr_status;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_limit_d;
    logic [WIDTH-1:0] w_left_evt;
    logic [WIDTH-1:0] w_right_evt;
    logic [WIDTH-1:0] w_left_d;
    logic [WIDTH-1:0] w_right_d;
    logic             w_left_moved;
    logic             w_right_moved;
    logic             w_left_chg_d;
    logic             w_right_chg_d;
    logic [31:0]      w_rdata;

    // One encoder step against the current limit; simultaneous cw+ccw cancels.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] pos,
        input logic             cw,
        input logic             ccw,
        input logic [WIDTH-1:0] lim,
        input logic             wrap
    );
        logic [WIDTH-1:0] nxt;
        nxt = pos;
        if (cw && !ccw) begin
            if (pos >= lim) begin
                nxt = wrap ? '0 : lim;
            end else begin
                nxt = pos + WIDTH'(1);
            end
        end else if (ccw && !cw) begin
            if (pos == '0) begin
                nxt = wrap ? lim : '0;
            end else begin
                nxt = pos - WIDTH'(1);
            end
        end
        return nxt;
    endfunction

    function automatic logic [WIDTH-1:0] f_clamp(
        input logic [WIDTH-1:0] val,
        input logic [WIDTH-1:0] lim
    );
        return (val > lim) ? lim : val;
    endfunction

    always_comb begin
        w_wdata     = avs_writedata[WIDTH-1:0];
        w_wr_left   = avs_write && (avs_address == AddrLeft);
        w_wr_right  = avs_write && (avs_address == AddrRight);
        w_wr_limit  = avs_write && (avs_address == AddrLimit);
        w_wr_ctrl   = avs_write && (avs_address == AddrCtrl);
        w_wr_status = avs_write && (avs_address == AddrStatus);
    end

    // Events are judged against the old limit; the result is then clamped to the new one.
    always_comb begin
        w_limit_d   = w_wr_limit ? w_wdata : r_limit;

        w_left_evt  = f_step(r_left_pos, rotary_left_cw, rotary_left_ccw, r_limit, r_wrap);
        w_right_evt = f_step(r_right_pos, rotary_right_cw, rotary_right_ccw, r_limit, r_wrap);

        w_left_moved  = !w_wr_left && (w_left_evt != r_left_pos);
        w_right_moved = !w_wr_right && (w_right_evt != r_right_pos);

        w_left_d  = f_clamp(w_wr_left ? f_clamp(w_wdata, r_limit) : w_left_evt, w_limit_d);
        w_right_d = f_clamp(w_wr_right ? f_clamp(w_wdata, r_limit) : w_right_evt, w_limit_d);

        // Set beats a same-cycle W1C clear.
        w_left_chg_d  = (r_left_chg && !(w_wr_status && avs_writedata[0])) || w_left_moved;
        w_right_chg_d = (r_right_chg && !(w_wr_status && avs_writedata[1])) || w_right_moved;
    end

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            AddrLeft:   w_rdata = 32'(r_left_pos);
            AddrRight:  w_rdata = 32'(r_right_pos);
            AddrLimit:  w_rdata = 32'(r_limit);
            AddrCtrl:   w_rdata = {30'd0, r_irq_en, r_wrap};
            AddrStatus: w_rdata = {30'd0, r_right_chg, r_left_chg};
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_left_pos  <= '0;
            r_right_pos <= '0;
            r_limit     <= WIDTH'(LIMIT_RESET);
            r_wrap      <= 1'b0;
            r_irq_en    <= 1'b0;
            r_left_chg  <= 1'b0;
            r_right_chg <= 1'b0;
            r_irq       <= 1'b0;
            r_readdata  <= '0;
        end else begin
            r_left_pos  <= w_left_d;
            r_right_pos <= w_right_d;
            r_limit     <= w_limit_d;
            if (w_wr_ctrl) begin
                r_wrap   <= avs_writedata[0];
                r_irq_en <= avs_writedata[1];
            end
            r_left_chg  <= w_left_chg_d;
            r_right_chg <= w_right_chg_d;
            r_irq       <= r_irq_en && (r_left_chg || r_right_chg);
            if (avs_read) begin
                r_readdata <= w_rdata;
            end
        end
    end

    assign avs_readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_rotary_accum.sv
// Self-checking bench for rotary_accum: directed scenarios plus randomized traffic
// compared against a modular-arithmetic reference model.
module tb_rotary_accum;

    localparam int WIDTH = 8;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rotary_left_cw = 1'b0;
    logic        rotary_left_ccw = 1'b0;
    logic        rotary_right_cw = 1'b0;
    logic        rotary_right_ccw = 1'b0;
    logic [2:0]  avs_address = 3'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_left, m_right, m_limit, m_wrap, m_irqen, m_lchg, m_rchg, m_irq;
    logic [31:0] m_rd;

    rotary_accum #(.WIDTH(WIDTH), .LIMIT_RESET(255)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .rotary_left_cw   (rotary_left_cw),
        .rotary_left_ccw  (rotary_left_ccw),
        .rotary_right_cw  (rotary_right_cw),
        .rotary_right_ccw (rotary_right_ccw),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_readdata     (avs_readdata),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Next position of one channel: write loads clamped value, otherwise step mod (LIMIT+1)
    // when wrapping or saturate within [0, LIMIT]; finally clamp to the new limit.
    function automatic int chan_next(input int pos, input bit cw, input bit ccw, input bit wr,
                                     input int wd, input int new_lim, output bit moved);
        int p;
        p = pos;
        if (wr) p = imin(wd, m_limit);
        else if (cw && !ccw) p = m_wrap ? (pos + 1) % (m_limit + 1) : imin(pos + 1, m_limit);
        else if (ccw && !cw) p = m_wrap ? (pos + m_limit) % (m_limit + 1) : ((pos == 0) ? 0 : pos - 1);
        moved = !wr && (p != pos);
        return imin(p, new_lim);
    endfunction

    task automatic model_clock();
        int  wd, nlim, nl, nr;
        bit  lmv, rmv, wr;
        logic [31:0] nrd;
        if (!reset_n) begin
            m_left = 0; m_right = 0; m_limit = 255; m_wrap = 0; m_irqen = 0;
            m_lchg = 0; m_rchg = 0; m_irq = 0; m_rd = 32'd0;
            return;
        end
        wd  = int'(avs_writedata) & MASK;
        wr  = avs_write;
        nrd = m_rd;
        if (avs_read) begin
            case (avs_address)
                3'd0: nrd = 32'(m_left);
                3'd1: nrd = 32'(m_right);
                3'd2: nrd = 32'(m_limit);
                3'd3: nrd = 32'(m_irqen * 2 + m_wrap);
                3'd4: nrd = 32'(m_rchg * 2 + m_lchg);
                default: nrd = 32'd0;
            endcase
        end
        nlim = (wr && avs_address == 3'd2) ? wd : m_limit;
        nl = chan_next(m_left, rotary_left_cw, rotary_left_ccw, wr && avs_address == 3'd0, wd,
                       nlim, lmv);
        nr = chan_next(m_right, rotary_right_cw, rotary_right_ccw, wr && avs_address == 3'd1,
                       wd, nlim, rmv);
        m_irq = m_irqen & (m_lchg | m_rchg);
        if (wr && avs_address == 3'd4) begin
            if (avs_writedata[0]) m_lchg = 0;
            if (avs_writedata[1]) m_rchg = 0;
        end
        if (lmv) m_lchg = 1;
        if (rmv) m_rchg = 1;
        if (wr && avs_address == 3'd3) begin
            m_wrap  = int'(avs_writedata[0]);
            m_irqen = int'(avs_writedata[1]);
        end
        m_left = nl; m_right = nr; m_limit = nlim; m_rd = nrd;
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        rotary_left_cw = 0; rotary_left_ccw = 0; rotary_right_cw = 0; rotary_right_ccw = 0;
        avs_read = 0; avs_write = 0;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        avs_address = addr; avs_write = 1; avs_writedata = data;
        step();
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        avs_address = addr; avs_read = 1;
        step();
        data = avs_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 0;
        step(); step();
        reset_n = 1;
        n_checks++;
        if (avs_readdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_readdata got %0h want 0", avs_readdata);
        end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        bus_read(3'd2, d);
        n_checks++;
        if (d !== 32'd255) begin n_fail++; $display("FAIL reset_limit got %0d want 255", d); end
        bus_read(3'd3, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl got %0d want 0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            rotary_left_cw = 1;
            step();
        end
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 32'd3) begin n_fail++; $display("FAIL b2b_left got %0d want 3", d); end
        bus_read(3'd4, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL b2b_status got %0h want 1", d); end
        bus_read(3'd1, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL b2b_right got %0d want 0", d); end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        bus_write(3'd2, 32'd5);
        bus_write(3'd3, 32'd1);
        bus_write(3'd0, 32'd5);
        bus_write(3'd4, 32'd3);
        rotary_left_cw = 1; step();
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL wrap_up got %0d want 0", d); end
        rotary_left_ccw = 1; step();
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 32'd5) begin n_fail++; $display("FAIL wrap_down got %0d want 5", d); end
        bus_write(3'd3, 32'd0);
        bus_write(3'd4, 32'd3);
        rotary_left_cw = 1; step();
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 32'd5) begin n_fail++; $display("FAIL sat_hold got %0d want 5", d); end
        bus_read(3'd4, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL sat_status got %0h want 0", d); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        bus_write(3'd2, 32'd255);
        bus_write(3'd1, 32'd10);
        bus_write(3'd0, 32'd20);
        bus_write(3'd4, 32'd3);
        rotary_right_cw = 1; rotary_right_ccw = 1; rotary_left_cw = 1;
        step();
        bus_read(3'd1, d);
        n_checks++;
        if (d !== 32'd10) begin n_fail++; $display("FAIL cancel_right got %0d want 10", d); end
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 32'd21) begin n_fail++; $display("FAIL indep_left got %0d want 21", d); end
        bus_read(3'd4, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL cancel_status got %0h want 1", d); end
    endtask

    task automatic test_limit_clamp();
        logic [31:0] d;
        bus_write(3'd1, 32'd200);
        bus_write(3'd4, 32'd3);
        bus_write(3'd2, 32'd100);
        bus_read(3'd1, d);
        n_checks++;
        if (d !== 32'd100) begin n_fail++; $display("FAIL clamp_right got %0d want 100", d); end
        bus_write(3'd0, 32'd250);
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 32'd100) begin n_fail++; $display("FAIL clamp_write got %0d want 100", d); end
        bus_read(3'd4, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL clamp_status got %0h want 0", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        bus_write(3'd2, 32'd255);
        bus_write(3'd3, 32'd2);
        bus_write(3'd4, 32'd3);
        step();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle got %b want 0", irq); end
        rotary_left_cw = 1; step();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b want 0", irq); end
        step();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_assert got %b want 1", irq); end
        avs_address = 3'd4; avs_write = 1; avs_writedata = 32'h1; rotary_left_cw = 1;
        step();
        bus_read(3'd4, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL set_wins got %0h want 1", d); end
        bus_write(3'd4, 32'h1);
        step();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        bus_write(3'd0, 32'd7);
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 32'd7) begin n_fail++; $display("FAIL pre_reset_left got %0d want 7", d); end
        reset_n = 0; rotary_left_cw = 1;
        step();
        reset_n = 1;
        n_checks++;
        if (avs_readdata !== 32'd0) begin
            n_fail++; $display("FAIL midreset_readdata got %0h want 0", avs_readdata);
        end
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL midreset_left got %0d want 0", d); end
        bus_read(3'd2, d);
        n_checks++;
        if (d !== 32'd255) begin n_fail++; $display("FAIL midreset_limit got %0d want 255", d); end
        rotary_left_cw = 1; step();
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL first_event got %0d want 1", d); end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 1500; i++) begin
            rotary_left_cw   = ($urandom % 3 == 0);
            rotary_left_ccw  = ($urandom % 3 == 0);
            rotary_right_cw  = ($urandom % 3 == 0);
            rotary_right_ccw = ($urandom % 3 == 0);
            avs_address = 3'($urandom % 8);
            r = int'($urandom % 16);
            if (r < 6) begin
                avs_read = 1;
            end else if (r < 9) begin
                avs_write = 1;
                avs_writedata = $urandom;
                if (avs_address == 3'd2 && ($urandom % 4 != 0))
                    avs_writedata = 32'($urandom_range(0, 12));
            end
            reset_n = ($urandom % 200 != 0);
            step();
            n_checks++;
            if (avs_readdata !== m_rd) begin
                n_fail++;
                $display("FAIL rand_readdata cyc %0d got %0h want %0h", i, avs_readdata, m_rd);
            end
            n_checks++;
            if (irq !== m_irq[0]) begin
                n_fail++; $display("FAIL rand_irq cyc %0d got %b want %b", i, irq, m_irq[0]);
            end
        end
        reset_n = 1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_simultaneous();
        test_limit_clamp();
        test_irq();
        test_reset_midcount();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
